// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit.
//   - Forwarding mux select encodings driven on ForwardAE/ForwardBE.
//   - Multiply-hold FSM state codes.
//   - fwd_sel(): forwarding priority function shared by both source operands.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from ResultW
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALUOutM

  // r15 is the PC; its value never travels through the forwarding paths.
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_BUSY = 1'b1
  } mul_state_e;

  // The Memory stage holds the younger result, so it wins over Writeback.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic       reg_write_m,
                                         input logic [3:0] wa_m,
                                         input logic       reg_write_w,
                                         input logic [3:0] wa_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (reg_write_m && (ra == wa_m) && (wa_m != REG_PC)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (ra == wa_w) && (wa_w != REG_PC)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of signals between the pipeline (controller + datapath) and the
// hazard unit.
//   master : pipeline side - drives register addresses and stage-qualified
//            control, receives stall/flush/forward controls.
//   slave  : hazard unit side.
// CNT_W sizes the StallCycles performance counter.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);

  logic [3:0]       RA1D;
  logic [3:0]       RA2D;
  logic [3:0]       RA1E;
  logic [3:0]       RA2E;
  logic [3:0]       WA3E;
  logic [3:0]       WA3M;
  logic [3:0]       WA3W;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             MemtoRegE;
  logic             MulOpE;
  logic             PCWrPendingF;
  logic             PCSrcW;
  logic             BranchTakenD;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             MulBusy;
  logic [CNT_W-1:0] StallCycles;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteM, RegWriteW, MemtoRegE, MulOpE,
    output PCWrPendingF, PCSrcW, BranchTakenD,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, MulBusy, StallCycles
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteM, RegWriteW, MemtoRegE, MulOpE,
    input  PCWrPendingF, PCSrcW, BranchTakenD,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, MulBusy, StallCycles
  );

endinterface

// File: rtl/hazard_unit_mul_hold_fsm.sv
// Multi-cycle multiply hold. Keeps a multiply in Execute for MUL_CYCLES
// cycles by raising mul_stall_o for the first MUL_CYCLES-1 of them.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   mul_op_i     : valid multiply in Execute
//   mul_stall_o  : hold request (combinational from state)
module hazard_unit_mul_hold_fsm
  import hazard_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic mul_op_i,
  output logic mul_stall_o
);

  localparam bit HOLD_EN = (MUL_CYCLES > 1);
  localparam int CW      = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam int LOAD_I  = (MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0;
  localparam logic [CW-1:0] CNT_LOAD = LOAD_I[CW-1:0];

  mul_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_stall_o = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (HOLD_EN && mul_op_i) begin
          mul_stall_o = 1'b1;
          cnt_d       = CNT_LOAD;
          state_d     = MS_BUSY;
        end
      end
      MS_BUSY: begin
        // cnt==0 is the release cycle: the multiply advances to M and
        // mul_op_i is ignored so the same instruction cannot retrigger.
        if (cnt_q != '0) begin
          mul_stall_o = 1'b1;
          cnt_d       = cnt_q - CW'(1);
        end else begin
          state_d = MS_IDLE;
        end
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use interlock, branch /
// PC-write flushes, multi-cycle multiply hold and a saturating count of
// fetch-stall cycles.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   hz         : hazard_unit_if.slave - addresses and stage-qualified
//                control in; ForwardAE/BE, Stall F/D/E, Flush D/E/M,
//                MulBusy and StallCycles out.
// While reset is high every stall/flush output is 0 and forwarding selects
// the register file.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.slave  hz
);

  logic             mul_stall;
  logic             ldr_stall;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall_f, stall_d, stall_e;
  logic             flush_d, flush_e, flush_m, mul_busy;
  logic [CNT_W-1:0] StallCycles_q, StallCycles_d;

  hazard_unit_mul_hold_fsm #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul_hold_fsm (
    .clk         (clk),
    .reset       (reset),
    .mul_op_i    (hz.MulOpE),
    .mul_stall_o (mul_stall)
  );

  assign ldr_stall = hz.MemtoRegE && ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));

  always_comb begin
    fwd_a    = FWD_RF;
    fwd_b    = FWD_RF;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    mul_busy = 1'b0;
    if (!reset) begin
      fwd_a = fwd_sel(hz.RA1E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
      fwd_b = fwd_sel(hz.RA2E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
      if (mul_stall) begin
        // Freeze F/D/E and bubble M. Branch and load-use decisions are
        // dropped here; they are re-evaluated once the multiply releases.
        mul_busy = 1'b1;
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        flush_m  = 1'b1;
      end else begin
        stall_f = ldr_stall || hz.PCWrPendingF;
        stall_d = ldr_stall;
        flush_d = hz.PCWrPendingF || hz.PCSrcW || hz.BranchTakenD;
        flush_e = ldr_stall || hz.BranchTakenD;
      end
    end
  end

  always_comb begin
    StallCycles_d = StallCycles_q;
    if (stall_f && (StallCycles_q != '1)) begin
      StallCycles_d = StallCycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCycles_q <= '0;
    end else begin
      StallCycles_q <= StallCycles_d;
    end
  end

  assign hz.ForwardAE   = fwd_a;
  assign hz.ForwardBE   = fwd_b;
  assign hz.StallF      = stall_f;
  assign hz.StallD      = stall_d;
  assign hz.StallE      = stall_e;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushM      = flush_m;
  assign hz.MulBusy     = mul_busy;
  assign hz.StallCycles = StallCycles_q;

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard block that sits across from the pipeline controller.
- Consumes the controller's stage-qualified control outputs (RegWriteM/W, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenD, MulOpE) plus register addresses from the datapath.
- Drives stall, flush and forwarding controls back into the controller (FlushE) and the datapath.
- Adds a multi-cycle multiply hold FSM and a saturating stall-cycle performance counter.

Parameters:
MUL_CYCLES, 3, cycles a multiply occupies Execute (>=1; 1 = no hold)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
RA1D  in  4  Decode source reg 1
RA2D  in  4  Decode source reg 2
RA1E  in  4  Execute source reg 1
RA2E  in  4  Execute source reg 2
WA3E  in  4  Execute destination reg
WA3M  in  4  Memory destination reg
WA3W  in  4  Writeback destination reg
RegWriteM  in  1  gated register write, Memory stage
RegWriteW  in  1  register write, Writeback stage
MemtoRegE  in  1  load in Execute
MulOpE  in  1  valid multiply in Execute (already condition-qualified upstream)
PCWrPendingF  in  1  PC write in D/E/M
PCSrcW  in  1  PC write retiring
BranchTakenD  in  1  early branch resolved taken
ForwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUOutM
ForwardBE  out  2  SrcB select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E registers, including controller E-stage regs
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E control regs (controller FlushE)
FlushM  out  1  insert bubble into E/M register
MulBusy  out  1  multiply hold active
StallCycles  out  CNT_W  saturating count of StallF cycles

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (port reset).
- Reset state: FSM IDLE, mul counter 0, StallCycles 0. While reset=1 all stall/flush outputs are 0 and ForwardAE/BE are 00.
- Forwarding (combinational, per source X in {1,2}):
  - 10 if RegWriteM & RAXE==WA3M & WA3M!=15.
  - Else 01 if RegWriteW & RAXE==WA3W & WA3W!=15.
  - Else 00. M takes priority over W.
- Load-use: ldrStall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
- Multiply hold FSM (states IDLE, BUSY; counter width clog2(MUL_CYCLES)):
  - IDLE & MulOpE & MUL_CYCLES>1: mulStall=1; load cnt=MUL_CYCLES-2; next BUSY.
  - BUSY, cnt!=0: mulStall=1; cnt decrements.
  - BUSY, cnt==0: mulStall=0 (release cycle, multiply advances to M); next IDLE. MulOpE is ignored in this cycle, so there is no retrigger on the same instruction.
  - Net effect: the multiply occupies E for MUL_CYCLES cycles with MUL_CYCLES-1 stall cycles. Back-to-back multiplies retrigger from IDLE.
  - MulBusy = mulStall.
- Output equations when mulStall=1 (hold has priority):
  - StallF = StallD = StallE = 1, FlushM = 1.
  - FlushD = FlushE = 0. BranchTakenD and ldrStall are suppressed, since both are re-evaluated after release.
- Output equations when mulStall=0:
  - StallF = ldrStall | PCWrPendingF.
  - StallD = ldrStall.
  - StallE = 0, FlushM = 0.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenD.
  - FlushE = ldrStall | BranchTakenD.
- PCSrcW=1 during a multiply hold cannot occur, because PCWrPendingF already flushed younger instructions. The hold keeps priority anyway.
- StallCycles: increments each cycle StallF=1; holds at 2^CNT_W-1.
- Reset mid-hold: FSM returns to IDLE on the next edge, and the multiply in E is discarded by the pipeline reset.

Decomposition:
- Shared include holds the forwarding encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the FSM state codes.
- One natural sub-module, mul_hold_fsm (counter + state; outputs mulStall). Everything else is combinational in hazard_unit.

Test Plan:
- Forwarding priority: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. WA3M=WA3W=15 -> 00.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=1, StallD=1, FlushE=1, FlushD=0. StallCycles increments by 1.
- Branch/PC write: BranchTakenD=1 -> FlushD=1, FlushE=1. PCWrPendingF=1 -> StallF=1, FlushD=1. PCSrcW=1 alone -> FlushD=1 only.
- Multiply, MUL_CYCLES=3, MulOpE held 3 cycles -> StallF/D/E=1 and FlushM=1 for cycles 0-1, all 0 in cycle 2. Back-to-back second MulOpE in cycle 3 -> stalls again. With BranchTakenD=1 during hold -> FlushD=0, FlushE=0.
- Reset mid-hold: assert reset in cycle 1 of a hold -> next cycle MulBusy=0, StallCycles=0, all flush/stall 0. MUL_CYCLES=1 build -> MulOpE never stalls.
- Counter saturation with CNT_W=4: 20 consecutive StallF cycles -> StallCycles=15.
